// File: rtl/vga_cell_scanner_pkg.sv
// Shared constants and types for the cell-based VGA scan-out path.
package vga_cell_scanner_pkg;

    // 640x480 @ 60 Hz timing, in pixels (horizontal) and lines (vertical)
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // One RAM word colours a square cell of 2^CELL_SHIFT pixels per edge
    localparam int CELL_SHIFT_DEF    = 3;
    localparam int CELLS_PER_ROW_DEF = H_VISIBLE_DEF >> CELL_SHIFT_DEF;

    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 8;

    // Colour bits inside a RAM word: {R,G,B} in the low three bits
    localparam int RGB_WIDTH     = 3;
    localparam int RGB_RED_BIT   = 2;
    localparam int RGB_GREEN_BIT = 1;
    localparam int RGB_BLUE_BIT  = 0;

    // Per-pixel decode that travels down the pipeline next to the RAM data
    typedef struct packed {
        logic visible;
        logic hsync_n;
        logic vsync_n;
        logic frame_start;
    } scan_flags_t;

    // Value of the flag pipeline while idle or in reset: blank, syncs inactive
    localparam scan_flags_t SCAN_FLAGS_IDLE = '{
        visible:     1'b0,
        hsync_n:     1'b1,
        vsync_n:     1'b1,
        frame_start: 1'b0
    };

    // Counter width able to hold 0..total-1
    function automatic int count_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_cell_scanner_if.sv
// RAM read port plus video outputs of the cell scanner.
interface vga_cell_scanner_if
    import vga_cell_scanner_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [ADDR_WIDTH-1:0] read_address;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  hsync;
    logic                  vsync;
    logic                  red;
    logic                  green;
    logic                  blue;
    logic                  frame_start;

    // Scanner side: drives the RAM address and the video pins
    modport master (
        output read_address,
        input  read_data,
        output hsync,
        output vsync,
        output red,
        output green,
        output blue,
        output frame_start
    );

    // RAM / display side
    modport slave (
        input  read_address,
        output read_data,
        input  hsync,
        input  vsync,
        input  red,
        input  green,
        input  blue,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing_counter.sv
// Raster H/V counters with visible, sync and frame-start decode (stage 0).
module vga_timing_counter
    import vga_cell_scanner_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int H_CNT_W   = count_width(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
    parameter int V_CNT_W   = count_width(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [H_CNT_W-1:0] h_count,
    output logic [V_CNT_W-1:0] v_count,
    output scan_flags_t        flags
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_CNT_W-1:0] H_LAST       = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_VIS_END    = H_CNT_W'(H_VISIBLE);
    localparam logic [H_CNT_W-1:0] H_SYNC_START = H_CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_CNT_W-1:0] H_SYNC_END   = H_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [V_CNT_W-1:0] V_LAST       = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_VIS_END    = V_CNT_W'(V_VISIBLE);
    localparam logic [V_CNT_W-1:0] V_SYNC_START = V_CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_CNT_W-1:0] V_SYNC_END   = V_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [H_CNT_W-1:0] h_count_reg;
    logic [H_CNT_W-1:0] h_count_next;
    logic [V_CNT_W-1:0] v_count_reg;
    logic [V_CNT_W-1:0] v_count_next;

    // Next raster position: H advances every pixel, V advances on the last pixel of a line
    always_comb begin
        h_count_next = h_count_reg + 1'b1;
        v_count_next = v_count_reg;
        if (h_count_reg == H_LAST) begin
            h_count_next = '0;
            if (v_count_reg == V_LAST) begin
                v_count_next = '0;
            end else begin
                v_count_next = v_count_reg + 1'b1;
            end
        end
    end

    // Raster position register; reset parks the scan at pixel (0,0)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
        end
    end

    // Decode the current position into visible, active-low syncs and frame start
    always_comb begin
        flags             = SCAN_FLAGS_IDLE;
        flags.visible     = (h_count_reg < H_VIS_END) && (v_count_reg < V_VIS_END);
        flags.hsync_n     = !((h_count_reg >= H_SYNC_START) && (h_count_reg < H_SYNC_END));
        flags.vsync_n     = !((v_count_reg >= V_SYNC_START) && (v_count_reg < V_SYNC_END));
        flags.frame_start = (h_count_reg == '0) && (v_count_reg == '0);
    end

    assign h_count = h_count_reg;
    assign v_count = v_count_reg;

endmodule

// File: rtl/vga_cell_scanner.sv
// Scans the raster, reads one RAM cell word per pixel and emits RGB with
// matched syncs. Outputs lag the raster counters by two pixel clocks.
module vga_cell_scanner
    import vga_cell_scanner_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int CELL_SHIFT = CELL_SHIFT_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    vga_cell_scanner_if.master  bus
);
    localparam int H_CNT_W       = count_width(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam int V_CNT_W       = count_width(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam int CELLS_PER_ROW = H_VISIBLE >> CELL_SHIFT;

    logic [H_CNT_W-1:0]    h_count;
    logic [V_CNT_W-1:0]    v_count;
    scan_flags_t           flags;

    logic [ADDR_WIDTH-1:0] cell_row;
    logic [ADDR_WIDTH-1:0] cell_col;
    logic [ADDR_WIDTH-1:0] cell_address;

    scan_flags_t           s1_flags_reg;
    logic                  hsync_reg;
    logic                  vsync_reg;
    logic                  frame_start_reg;
    logic [RGB_WIDTH-1:0]  colour;

    // Word bits above the colour field carry no meaning for this display
    logic                  unused_data_bits;
    assign unused_data_bits = ^bus.read_data[DATA_WIDTH-1:RGB_WIDTH];

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .H_CNT_W   (H_CNT_W),
        .V_CNT_W   (V_CNT_W)
    ) u_timing (
        .Clock   (Clock),
        .Reset   (Reset),
        .h_count (h_count),
        .v_count (v_count),
        .flags   (flags)
    );

    // Cell index of the current pixel; arithmetic wraps at ADDR_WIDTH bits
    always_comb begin
        cell_row     = ADDR_WIDTH'(v_count >> CELL_SHIFT);
        cell_col     = ADDR_WIDTH'(h_count >> CELL_SHIFT);
        cell_address = cell_row * ADDR_WIDTH'(CELLS_PER_ROW) + cell_col;
    end

    // Blanking pixels read address 0 so the RAM port sees a stable address
    assign bus.read_address = flags.visible ? cell_address : '0;

    // Stage 1: hold the decode while the RAM registers the word for this pixel
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_flags_reg <= SCAN_FLAGS_IDLE;
        end else begin
            s1_flags_reg <= flags;
        end
    end

    // Stage 2: syncs and frame start line up with the colour registered below
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_reg       <= s1_flags_reg.hsync_n;
            vsync_reg       <= s1_flags_reg.vsync_n;
            frame_start_reg <= s1_flags_reg.frame_start;
        end
    end

    // Stage 2 colour: one register per channel, gated to black outside the visible area
    for (genvar gi = 0; gi < RGB_WIDTH; gi++) begin : g_channel
        logic channel_reg;

        // Capture this channel of the RAM word for visible pixels only
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                channel_reg <= 1'b0;
            end else begin
                channel_reg <= s1_flags_reg.visible & bus.read_data[gi];
            end
        end

        assign colour[gi] = channel_reg;
    end

    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.red         = colour[RGB_RED_BIT];
    assign bus.green       = colour[RGB_GREEN_BIT];
    assign bus.blue        = colour[RGB_BLUE_BIT];

endmodule

// File: tb/tb_vga_cell_scanner.sv
// Bench for vga_cell_scanner: a full-size instance plus a shrunken-raster
// instance (so whole frames fit in a short run), both compared every pixel
// against a position-arithmetic model of the raster.
module tb_vga_cell_scanner;

    typedef struct {
        int hv, hf, hsy, hb;
        int vv, vf, vsy, vb;
    } geom_t;

    localparam int CS = 3;

    geom_t gd = '{640, 16, 96, 48, 480, 10, 2, 33};
    geom_t gs = '{64, 4, 8, 4, 48, 2, 2, 3};

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    vga_cell_scanner_if bus_d ();
    vga_cell_scanner_if bus_s ();

    vga_cell_scanner dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_d)
    );

    vga_cell_scanner #(
        .H_VISIBLE (64), .H_FRONT (4), .H_SYNC (8), .H_BACK (4),
        .V_VISIBLE (48), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .CELL_SHIFT (3), .ADDR_WIDTH (13), .DATA_WIDTH (8)
    ) dut_small (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_s)
    );

    // Framebuffer RAMs with one clock of read latency
    logic [7:0] mem_d [0:8191];
    logic [7:0] mem_s [0:8191];
    always @(posedge Clock) bus_d.read_data <= mem_d[bus_d.read_address];
    always @(posedge Clock) bus_s.read_data <= mem_s[bus_s.read_address];

    int  total_checks  = 0;
    int  passed_checks = 0;
    int  k             = 0;    // rising edges since the last reset release
    bit  in_reset      = 1'b1;
    logic prev_hs_d    = 1'b1;
    int  last_fall     = -1;
    int  last_fs       = -1;
    int  vs_low        = 0;

    function automatic int htot(geom_t g);
        return g.hv + g.hf + g.hsy + g.hb;
    endfunction

    function automatic int vtot(geom_t g);
        return g.vv + g.vf + g.vsy + g.vb;
    endfunction

    function automatic bit in_view(geom_t g, int n);
        int x;
        int y;
        x = n % htot(g);
        y = (n / htot(g)) % vtot(g);
        return (x < g.hv) && (y < g.vv);
    endfunction

    function automatic int cell_of(geom_t g, int n);
        int x;
        int y;
        x = n % htot(g);
        y = (n / htot(g)) % vtot(g);
        if (!in_view(g, n)) return 0;
        return (y >> CS) * (g.hv >> CS) + (x >> CS);
    endfunction

    // Expected {address, hsync, vsync, r, g, b, frame_start} after k edges
    function automatic logic [18:0] model_out(geom_t g, bit rst, int kk, logic [7:0] word);
        logic [12:0] a;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [2:0]  rgb;
        int          n;
        int          x;
        int          y;
        a   = rst ? 13'd0 : 13'(cell_of(g, kk));
        hs  = 1'b1;
        vs  = 1'b1;
        fs  = 1'b0;
        rgb = 3'b000;
        if (!rst && kk >= 2) begin
            n   = kk - 2;
            x   = n % htot(g);
            y   = (n / htot(g)) % vtot(g);
            hs  = !((x >= g.hv + g.hf) && (x < g.hv + g.hf + g.hsy));
            vs  = !((y >= g.vv + g.vf) && (y < g.vv + g.vf + g.vsy));
            fs  = (n % (htot(g) * vtot(g))) == 0;
            rgb = in_view(g, n) ? word[2:0] : 3'b000;
        end
        return {a, hs, vs, rgb, fs};
    endfunction

    task automatic check_vec(input string tag, input logic [18:0] obs, input logic [18:0] expd);
        total_checks++;
        assert (obs === expd) passed_checks++;
        else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expd);
    endtask

    task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        total_checks++;
        assert (obs === expd) passed_checks++;
        else $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, expd);
    endtask

    task automatic check_all();
        logic [7:0] wd;
        logic [7:0] ws;
        wd = 8'h00;
        ws = 8'h00;
        if (!in_reset && k >= 2) begin
            wd = mem_d[cell_of(gd, k - 2)];
            ws = mem_s[cell_of(gs, k - 2)];
        end
        check_vec("scan_default",
                  {bus_d.read_address, bus_d.hsync, bus_d.vsync, bus_d.red, bus_d.green,
                   bus_d.blue, bus_d.frame_start},
                  model_out(gd, in_reset, k, wd));
        check_vec("scan_small",
                  {bus_s.read_address, bus_s.hsync, bus_s.vsync, bus_s.red, bus_s.green,
                   bus_s.blue, bus_s.frame_start},
                  model_out(gs, in_reset, k, ws));
    endtask

    // Sync pulse widths/spacing and frame period measured from the pins
    task automatic measure();
        if (prev_hs_d && !bus_d.hsync) begin
            if (last_fall >= 0) check_int("hsync_period", k - last_fall, htot(gd));
            last_fall = k;
        end
        if (!prev_hs_d && bus_d.hsync && last_fall >= 0)
            check_int("hsync_width", k - last_fall, gd.hsy);
        prev_hs_d = bus_d.hsync;
        if (!bus_s.vsync) vs_low++;
        if (bus_s.frame_start) begin
            if (last_fs >= 0) begin
                check_int("frame_period", k - last_fs, htot(gs) * vtot(gs));
                check_int("vsync_low", vs_low, gs.vsy * htot(gs));
            end
            last_fs = k;
            vs_low  = 0;
        end
    endtask

    task automatic clear_trackers();
        prev_hs_d = 1'b1;
        last_fall = -1;
        last_fs   = -1;
        vs_low    = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        if (!in_reset) k++;
        @(negedge Clock);
        check_all();
        measure();
    endtask

    task automatic release_reset();
        Reset    = 1'b0;
        in_reset = 1'b0;
        k        = 0;
        clear_trackers();
        check_all();
    endtask

    initial begin
        // Phase 1: word k carries k[2:0] in its colour bits, random elsewhere
        for (int i = 0; i < 8192; i++) begin
            mem_d[i] = {5'($urandom), 3'(i)};
            mem_s[i] = 8'($urandom);
        end
        for (int c = 0; c < 3; c++) tick();
        release_reset();
        for (int c = 0; c < 9300; c++) begin
            tick();
            if (k >= 2 && k < 18)
                check_int("line0_colour", {bus_d.red, bus_d.green, bus_d.blue}, ((k - 2) >> 3) & 7);
            if (k == 47 * 80 + 63)
                check_int("addr_last_cell", bus_s.read_address, 47);
            if (k == 64)
                check_int("addr_hblank", bus_s.read_address, 0);
            if (k <= 3)
                check_int("first_frame_start", bus_d.frame_start, (k == 2) ? 1 : 0);
        end

        // Phase 2: white top-left cell only; small RAM returns 0x07 on blanking reads
        Reset    = 1'b1;
        in_reset = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            mem_d[i] = 8'h00;
            mem_s[i] = 8'($urandom);
        end
        mem_d[0] = 8'h07;
        mem_s[0] = 8'h07;
        for (int c = 0; c < 3; c++) tick();
        release_reset();
        while (k < 1899) begin
            tick();
            if (k == 2)
                check_int("white_with_fs", {bus_d.frame_start, bus_d.red, bus_d.green, bus_d.blue}, 4'hF);
            if (k == 10)
                check_int("black_cell1", {bus_d.red, bus_d.green, bus_d.blue}, 0);
            if (k == 72)
                check_int("blank_colour", {bus_s.red, bus_s.green, bus_s.blue}, 0);
        end

        // Asynchronous reset between edges at raster position (300,2)
        @(posedge Clock);
        #3;
        Reset    = 1'b1;
        in_reset = 1'b1;
        #1;
        check_all();
        for (int c = 0; c < 3; c++) tick();
        release_reset();
        for (int c = 0; c < 4410; c++) begin
            tick();
            if (k <= 3)
                check_int("fs_after_reset", bus_d.frame_start, (k == 2) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
